pairing_arbiter: RTL and testbench

Round-robin scheduler that shares one Tate pairing core among `N_REQ` requesters. It accepts operand sets (x1, y1, x2, y2) over per-requester valid/ready handshakes and latches the winner's operands. It then launches the core with a one-cycle start pulse, waits for the core's `done`, and returns the result to the owning requester. It sits between the host-side requesters and the single `tate_pairing` instance.

---
 rtl/pairing_arbiter_pkg.sv | 19 +
 rtl/pairing_rr_pick.sv | 33 +++
 rtl/pairing_arbiter.sv | 152 +++++++++++++++
 tb/tb_pairing_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pairing_arbiter_pkg.sv
// Shared types and widths for the pairing arbiter slice.
package pairing_arbiter_pkg;

    // Field element width (WIDTH+1) and pairing result width (W6+1).
    localparam int unsigned ELEM_W = 194;
    localparam int unsigned RES_W  = 6 * ELEM_W;

    // Width of the optional BUSY watchdog counter.
    localparam int unsigned TO_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BUSY,
        ST_RESP
    } state_t;

endpackage

// File: rtl/pairing_rr_pick.sv
// Combinational round-robin selector: first active request after ptr, wrapping.
module pairing_rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins.
    always_comb begin
        int unsigned c;
        logic [IW-1:0] c_idx;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        c_idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            c     = (32'(ptr) + k) % N_REQ;
            c_idx = IW'(c);
            if (!any && req[c_idx]) begin
                any          = 1'b1;
                grant[c_idx] = 1'b1;
                idx          = c_idx;
            end
        end
    end

endmodule

// File: rtl/pairing_arbiter.sv
// Round-robin scheduler sharing one Tate pairing core among N_REQ requesters.
// Optional BUSY watchdog: define PAIRING_ARB_TIMEOUT_EN.
module pairing_arbiter
    import pairing_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned EW          = ELEM_W,
    parameter int unsigned RW          = RES_W,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*EW-1:0] req_x1,
    input  logic [N_REQ*EW-1:0] req_y1,
    input  logic [N_REQ*EW-1:0] req_x2,
    input  logic [N_REQ*EW-1:0] req_y2,
    output logic [N_REQ-1:0]  rsp_valid,
    input  logic [N_REQ-1:0]  rsp_ready,
    output logic [RW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic              core_start,
    output logic [EW-1:0]     core_x1,
    output logic [EW-1:0]     core_y1,
    output logic [EW-1:0]     core_x2,
    output logic [EW-1:0]     core_y2,
    input  logic              core_done,
    input  logic [RW-1:0]     core_out,
    output logic              busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("pairing_arbiter: parameter out of range");
    end

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [N_REQ-1:0] gsel;
    // Low during START and the first BUSY cycle so a stale done is ignored.
    logic             armed;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    pairing_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign busy = (state != ST_IDLE);

`ifdef PAIRING_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
    logic [TO_W-1:0] cnt;
    logic            err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Arbitration / launch / response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ptr        <= IW'(N_REQ - 1);
            gidx       <= '0;
            gsel       <= '0;
            armed      <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            core_start <= 1'b0;
            core_x1    <= '0;
            core_y1    <= '0;
            core_x2    <= '0;
            core_y2    <= '0;
`ifdef PAIRING_ARB_TIMEOUT_EN
            cnt        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            req_ready  <= '0;
            core_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        ptr       <= pick_idx;
                        gidx      <= pick_idx;
                        gsel      <= pick_grant;
                        req_ready <= pick_grant;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_x1    <= req_x1[gidx*EW +: EW];
                    core_y1    <= req_y1[gidx*EW +: EW];
                    core_x2    <= req_x2[gidx*EW +: EW];
                    core_y2    <= req_y2[gidx*EW +: EW];
                    core_start <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
                    armed <= 1'b0;
`ifdef PAIRING_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    armed <= 1'b1;
                    if (armed && core_done) begin
                        rsp_data  <= core_out;
                        rsp_valid <= gsel;
                        state     <= ST_RESP;
                    end
`ifdef PAIRING_ARB_TIMEOUT_EN
                    else if (cnt == TO_LIM) begin
                        rsp_data  <= '0;
                        rsp_valid <= gsel;
                        err_q     <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (|(rsp_ready & gsel)) begin
                        rsp_valid <= '0;
`ifdef PAIRING_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_arbiter.sv
// Directed self-checking bench for pairing_arbiter (N_REQ=3, narrow widths).
module tb_pairing_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned EW = 16;
    localparam int unsigned RW = 64;
    localparam logic [RW-1:0] MASK = 64'hFFFF_0000_FFFF_0000;
    // Known answer for requester 0 operands 1234/5678/9ABC/DEF0.
    localparam logic [RW-1:0] KAT  = 64'hEDCB_5678_6543_DEF0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*EW-1:0] req_x1, req_y1, req_x2, req_y2;
    logic [RW-1:0] rsp_data, core_out;
    logic          rsp_err, core_start, core_done, busy;
    logic [EW-1:0] core_x1, core_y1, core_x2, core_y2;

    logic [EW-1:0] op_x1 [N];
    logic [EW-1:0] op_y1 [N];
    logic [EW-1:0] op_x2 [N];
    logic [EW-1:0] op_y2 [N];

    int checks   = 0;
    int failures = 0;

    logic auto_core = 1'b1;
    logic man_done  = 1'b0;
    logic model_done = 1'b0;
    int   lat_cnt   = 0;

    pairing_arbiter #(
        .N_REQ       (N),
        .EW          (EW),
        .RW          (RW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x1     (req_x1),
        .req_y1     (req_y1),
        .req_x2     (req_x2),
        .req_y2     (req_y2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .core_start (core_start),
        .core_x1    (core_x1),
        .core_y1    (core_y1),
        .core_x2    (core_x2),
        .core_y2    (core_y2),
        .core_done  (core_done),
        .core_out   (core_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in core: result is a fixed mix of its operands, done 5 cycles after start.
    assign core_out  = {core_x1, core_y1, core_x2, core_y2} ^ MASK;
    assign core_done = auto_core ? model_done : man_done;

    always @(posedge clk) begin
        if (core_start) begin
            lat_cnt    <= 4;
            model_done <= 1'b0;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) model_done <= 1'b1;
        end
    end

    function automatic logic [RW-1:0] exp_res(input int i);
        return {op_x1[i], op_y1[i], op_x2[i], op_y2[i]} ^ MASK;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        step();
        while (req_ready == '0 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        step();
        while (rsp_valid == '0 && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic handshake(input string tag, input logic [N-1:0] rdy);
        rsp_ready = rdy;
        step();
        rsp_ready = '0;
        chk(tag, 64'(rsp_valid), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_core_x"}, {core_x1, core_y1, core_x2, core_y2}, 64'd0);
    endtask

    initial begin
        int n;
        op_x1[0] = 16'h1234; op_y1[0] = 16'h5678; op_x2[0] = 16'h9ABC; op_y2[0] = 16'hDEF0;
        op_x1[1] = 16'h1111; op_y1[1] = 16'h2222; op_x2[1] = 16'h3333; op_y2[1] = 16'h4444;
        op_x1[2] = 16'hA0A0; op_y1[2] = 16'hB1B1; op_x2[2] = 16'hC2C2; op_y2[2] = 16'hD3D3;
        req_x1 = {op_x1[2], op_x1[1], op_x1[0]};
        req_y1 = {op_y1[2], op_y1[1], op_y1[0]};
        req_x2 = {op_x2[2], op_x2[1], op_x2[0]};
        req_y2 = {op_y2[2], op_y2[1], op_y2[0]};
        req_valid = '0;
        rsp_ready = '0;

        // Reset state
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b1;
        step();

        // Single request from requester 0: fixed latencies and known answer
        req_valid = 3'b001;
        step();
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        chk("t1_busy", 64'(busy), 64'h1);
        req_valid = '0;
        step();
        chk("t1_core_start", 64'(core_start), 64'h1);
        chk("t1_req_ready_drop", 64'(req_ready), 64'h0);
        wait_rsp(n);
        chk("t1_rsp_latency", 64'(n), 64'd6);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_data", rsp_data, KAT);
        chk("t1_rsp_err", 64'(rsp_err), 64'h0);
        chk("t1_core_x", {core_x1, core_y1, core_x2, core_y2}, 64'h1234_5678_9ABC_DEF0);
        handshake("t1_rsp_drop", 3'b001);
        chk("t1_idle_busy", 64'(busy), 64'h0);

        // Backpressure on requester 1, requester 2 waiting
        req_valid = 3'b010;
        wait_ready();
        chk("t3_grant1", 64'(req_ready), 64'h2);
        req_valid = '0;
        wait_rsp(n);
        chk("t3_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t3_rsp_data", rsp_data, exp_res(1));
        req_valid = 3'b100;
        rsp_ready = 3'b101;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_hold_valid", 64'(rsp_valid), 64'h2);
            chk("t3_hold_data", rsp_data, exp_res(1));
            chk("t3_no_grant", 64'(req_ready), 64'h0);
        end
        rsp_ready = 3'b010;
        step();
        chk("t3_rsp_drop", 64'(rsp_valid), 64'h0);
        chk("t3_ready_r1", 64'(req_ready), 64'h0);
        step();
        chk("t3_grant2_r2", 64'(req_ready), 64'h4);
        rsp_ready = '0;
        req_valid = '0;
        wait_rsp(n);
        chk("t3_rsp2_valid", 64'(rsp_valid), 64'h4);
        chk("t3_rsp2_data", rsp_data, exp_res(2));
        handshake("t3_rsp2_drop", 3'b100);

        // Stale done held through START and first BUSY cycle
        auto_core = 1'b0;
        man_done  = 1'b1;
        req_valid = 3'b001;
        wait_ready();
        chk("t4_grant0", 64'(req_ready), 64'h1);
        req_valid = '0;
        step();
        chk("t4_core_start", 64'(core_start), 64'h1);
        step();
        chk("t4_no_rsp_busy0", 64'(rsp_valid), 64'h0);
        step();
        chk("t4_no_rsp_busy1", 64'(rsp_valid), 64'h0);
        man_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_rsp_low", 64'(rsp_valid), 64'h0);
        end
        man_done = 1'b1;
        step();
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t4_rsp_data", rsp_data, exp_res(0));
        handshake("t4_rsp_drop", 3'b001);
        man_done  = 1'b0;
        auto_core = 1'b1;

        // Reset in the middle of BUSY
        req_valid = 3'b010;
        wait_ready();
        chk("t5_grant1", 64'(req_ready), 64'h2);
        req_valid = '0;
        step();
        step();
        step();
        chk("t5_busy", 64'(busy), 64'h1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        step();
        step();
        reset = 1'b1;

        // All three requesting: grants 0,1,2,0 from reset pointer
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [N-1:0] oh;
            oh = 3'b001 << (k % 3);
            wait_ready();
            chk("t2_grant", 64'(req_ready), 64'(oh));
            wait_rsp(n);
            chk("t2_rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("t2_rsp_data", rsp_data, exp_res(k % 3));
            if (k == 3) req_valid = '0;
            rsp_ready = 3'b111;
            step();
            rsp_ready = '0;
            chk("t2_rsp_drop", 64'(rsp_valid), 64'h0);
        end

`ifdef PAIRING_ARB_TIMEOUT_EN
        // Watchdog: done never rises
        auto_core = 1'b0;
        man_done  = 1'b0;
        req_valid = 3'b010;
        wait_ready();
        chk("to_grant1", 64'(req_ready), 64'h2);
        req_valid = '0;
        step();
        chk("to_core_start", 64'(core_start), 64'h1);
        step();
        for (int i = 0; i < 100; i++) step();
        chk("to_not_yet", 64'(rsp_valid), 64'h0);
        step();
        chk("to_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("to_rsp_err", 64'(rsp_err), 64'h1);
        chk("to_rsp_data", rsp_data, 64'd0);
        handshake("to_rsp_drop", 3'b010);
        chk("to_err_clear", 64'(rsp_err), 64'h0);
        auto_core = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
